// File: rtl/sva_mon_pkg.sv
// Shared types, width helper and parameter-legality macro for the intersect monitor.
`ifndef SVA_MON_PKG_SV
`define SVA_MON_PKG_SV

// Elaboration-time guard: instantiates a failing generate block when cond is false.
`define SVA_MON_CHECK(label, cond) \
    if (!(cond)) begin : label \
        $error("sva_intersect_monitor: illegal parameter combination"); \
    end

package sva_mon_pkg;

    typedef enum logic [0:0] {
        MODE_FIRST = 1'b0,
        MODE_ALL   = 1'b1
    } intersect_mode_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`endif

// File: rtl/sva_intersect_lane.sv
// One intersect channel: age-indexed live vector, eligibility/retire logic and registered outputs.
module sva_intersect_lane
    import sva_mon_pkg::*;
#(
    parameter int              MIN_LEN = 0,
    parameter int              MAX_LEN = 7,
    parameter intersect_mode_e MODE    = MODE_FIRST,
    parameter int              LEN_W   = len_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic             end_a_i,
    input  logic             end_b_i,
    output logic             hit_o,
    output logic             expire_o,
    output logic             match_o,
    output logic             fail_o,
    output logic [LEN_W-1:0] match_len_o,
    output logic             busy_o
);

    // Age MAX_LEN never survives an update, so only ages 0..MAX_LEN-1 are stored.
    logic [MAX_LEN-1:0] live_r;
    logic [MAX_LEN:0]   eff_s;
    logic [MAX_LEN:0]   elig_s;
    logic [MAX_LEN:0]   retired_s;
    logic [MAX_LEN:0]   nxt_s;
    logic [LEN_W-1:0]   oldest_s;
    logic [LEN_W-1:0]   len_s;
    logic               hit_s;
    logic               expire_s;

    // Eligibility, oldest eligible age, retire set and expiry for this cycle.
    always_comb begin
        eff_s     = {live_r, start_i};
        elig_s    = '0;
        oldest_s  = '0;
        retired_s = '0;
        for (int d = 0; d <= MAX_LEN; d++) begin
            if (d >= MIN_LEN) begin
                elig_s[d] = eff_s[d];
            end else begin
                elig_s[d] = 1'b0;
            end
        end
        for (int d = 0; d <= MAX_LEN; d++) begin
            if (elig_s[d]) begin
                oldest_s = LEN_W'(d);
            end else begin
                oldest_s = oldest_s;
            end
        end
        hit_s = end_a_i & end_b_i & (|elig_s);
        if (hit_s) begin
            case (MODE)
                MODE_ALL:   retired_s = elig_s;
                MODE_FIRST: retired_s[oldest_s] = 1'b1;
                default:    retired_s[oldest_s] = 1'b1;
            endcase
            len_s = oldest_s;
        end else begin
            retired_s = '0;
            len_s     = '0;
        end
        expire_s = eff_s[MAX_LEN] & ~retired_s[MAX_LEN];
        nxt_s    = eff_s & ~retired_s;
    end

    assign hit_o    = hit_s;
    assign expire_o = expire_s;

    // Live vector ages by one each cycle; outputs register this cycle's verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_r      <= '0;
            match_o     <= 1'b0;
            fail_o      <= 1'b0;
            match_len_o <= '0;
            busy_o      <= 1'b0;
        end else if (clear_i) begin
            live_r      <= '0;
            match_o     <= 1'b0;
            fail_o      <= 1'b0;
            match_len_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            live_r      <= nxt_s[MAX_LEN-1:0];
            match_o     <= hit_s;
            fail_o      <= expire_s;
            match_len_o <= len_s;
            busy_o      <= |nxt_s[MAX_LEN-1:0];
        end
    end

endmodule

// File: rtl/sva_intersect_monitor.sv
// Multi-channel intersect checker: N_CH independent lanes plus shared saturating match/fail counters.
module sva_intersect_monitor
    import sva_mon_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MIN_LEN = 0,
    parameter int MAX_LEN = 7,
    parameter int MODE    = 0,
    parameter int CNT_W   = 16,
    localparam int LEN_W  = len_w(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic [N_CH-1:0]       start_i,
    input  logic [N_CH-1:0]       end_a_i,
    input  logic [N_CH-1:0]       end_b_i,
    output logic [N_CH-1:0]       match_o,
    output logic [N_CH-1:0]       fail_o,
    output logic [N_CH*LEN_W-1:0] match_len_o,
    output logic [N_CH-1:0]       busy_o,
    output logic [CNT_W-1:0]      match_cnt_o,
    output logic [CNT_W-1:0]      fail_cnt_o
);

    `SVA_MON_CHECK(g_chk_max, MAX_LEN >= 1)
    `SVA_MON_CHECK(g_chk_min, MIN_LEN >= 0 && MIN_LEN <= MAX_LEN)
    `SVA_MON_CHECK(g_chk_mode, MODE == 0 || MODE == 1)
    `SVA_MON_CHECK(g_chk_size, N_CH >= 1 && CNT_W >= 1)

    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0] hit_s;
    logic [N_CH-1:0] expire_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        sva_intersect_lane #(
            .MIN_LEN (MIN_LEN),
            .MAX_LEN (MAX_LEN),
            .MODE    (intersect_mode_e'(MODE)),
            .LEN_W   (LEN_W)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear_i     (clear_i),
            .start_i     (start_i[c]),
            .end_a_i     (end_a_i[c]),
            .end_b_i     (end_b_i[c]),
            .hit_o       (hit_s[c]),
            .expire_o    (expire_s[c]),
            .match_o     (match_o[c]),
            .fail_o      (fail_o[c]),
            .match_len_o (match_len_o[c*LEN_W +: LEN_W]),
            .busy_o      (busy_o[c])
        );
    end

    function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_CH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // The sum is widened so a burst of events cannot wrap before the clamp.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [PC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Counters advance in the same cycle the corresponding pulses are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_o <= '0;
            fail_cnt_o  <= '0;
        end else if (clear_i) begin
            match_cnt_o <= '0;
            fail_cnt_o  <= '0;
        end else begin
            match_cnt_o <= sat_add(match_cnt_o, popcount(hit_s));
            fail_cnt_o  <= sat_add(fail_cnt_o, popcount(expire_s));
        end
    end

endmodule

// File: tb/tb_sva_intersect_monitor.sv
// Bench for sva_intersect_monitor: four configurations driven in parallel against an attempt-list model.
module tb_sva_intersect_monitor;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_i = 1'b0;
    logic [3:0] start_i = 4'd0;
    logic [3:0] end_a_i = 4'd0;
    logic [3:0] end_b_i = 4'd0;

    logic [3:0]  m_o  [NI];
    logic [3:0]  f_o  [NI];
    logic [3:0]  b_o  [NI];
    logic [11:0] l_o  [NI];
    logic [15:0] mc_o [NI];
    logic [15:0] fc_o [NI];
    logic [1:0]  sat_mc;
    logic [1:0]  sat_fc;

    always #5 clk = ~clk;

    // Instance 0: FIRST/MIN0, 1: ALL/MIN0, 2: FIRST/MIN2, 3: FIRST/MIN0 with 2-bit counters.
    sva_intersect_monitor #(.N_CH(4), .MIN_LEN(0), .MAX_LEN(7), .MODE(0), .CNT_W(16)) u_first (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .start_i(start_i), .end_a_i(end_a_i), .end_b_i(end_b_i),
        .match_o(m_o[0]), .fail_o(f_o[0]), .match_len_o(l_o[0]), .busy_o(b_o[0]),
        .match_cnt_o(mc_o[0]), .fail_cnt_o(fc_o[0]));
    sva_intersect_monitor #(.N_CH(4), .MIN_LEN(0), .MAX_LEN(7), .MODE(1), .CNT_W(16)) u_all (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .start_i(start_i), .end_a_i(end_a_i), .end_b_i(end_b_i),
        .match_o(m_o[1]), .fail_o(f_o[1]), .match_len_o(l_o[1]), .busy_o(b_o[1]),
        .match_cnt_o(mc_o[1]), .fail_cnt_o(fc_o[1]));
    sva_intersect_monitor #(.N_CH(4), .MIN_LEN(2), .MAX_LEN(7), .MODE(0), .CNT_W(16)) u_min2 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .start_i(start_i), .end_a_i(end_a_i), .end_b_i(end_b_i),
        .match_o(m_o[2]), .fail_o(f_o[2]), .match_len_o(l_o[2]), .busy_o(b_o[2]),
        .match_cnt_o(mc_o[2]), .fail_cnt_o(fc_o[2]));
    sva_intersect_monitor #(.N_CH(4), .MIN_LEN(0), .MAX_LEN(7), .MODE(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .start_i(start_i), .end_a_i(end_a_i), .end_b_i(end_b_i),
        .match_o(m_o[3]), .fail_o(f_o[3]), .match_len_o(l_o[3]), .busy_o(b_o[3]),
        .match_cnt_o(sat_mc), .fail_cnt_o(sat_fc));

    assign mc_o[3] = {14'd0, sat_mc};
    assign fc_o[3] = {14'd0, sat_fc};

    int p_min  [NI] = '{0, 0, 2, 0};
    int p_all  [NI] = '{0, 1, 0, 0};
    int p_cmax [NI] = '{65535, 65535, 65535, 3};

    // Model: each live attempt is remembered by its start cycle; age = now - start.
    int          starts_q [16][$];
    int          cyc = 0;
    logic [3:0]  exp_m  [NI];
    logic [3:0]  exp_f  [NI];
    logic [3:0]  exp_b  [NI];
    logic [11:0] exp_l  [NI];
    int          exp_mc [NI];
    int          exp_fc [NI];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) starts_q[i].delete();
        for (int k = 0; k < NI; k++) begin
            exp_m[k] = 4'd0; exp_f[k] = 4'd0; exp_b[k] = 4'd0; exp_l[k] = 12'd0;
            exp_mc[k] = 0; exp_fc[k] = 0;
        end
    endtask

    task automatic model_eval(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        for (int k = 0; k < NI; k++) begin
            int nm = 0;
            int nf = 0;
            for (int c = 0; c < 4; c++) begin
                int idx = k * 4 + c;
                int oldest = -1;
                bit hit;
                bit fail = 1'b0;
                int tmp[$];
                if (s[c]) starts_q[idx].push_back(cyc);
                foreach (starts_q[idx][i]) begin
                    int age = cyc - starts_q[idx][i];
                    if (age >= p_min[k] && age <= 7 && age > oldest) oldest = age;
                end
                hit = a[c] && b[c] && (oldest >= 0);
                foreach (starts_q[idx][i]) begin
                    int age = cyc - starts_q[idx][i];
                    bit gone = hit && (age >= p_min[k]) && ((p_all[k] != 0) || age == oldest);
                    if (!gone) begin
                        if (age == 7) fail = 1'b1;
                        else tmp.push_back(starts_q[idx][i]);
                    end
                end
                starts_q[idx] = tmp;
                exp_m[k][c] = hit;
                exp_f[k][c] = fail;
                exp_b[k][c] = (tmp.size() != 0);
                exp_l[k][c*3 +: 3] = hit ? 3'(oldest) : 3'd0;
                nm += int'(hit);
                nf += int'(fail);
            end
            exp_mc[k] = (exp_mc[k] + nm > p_cmax[k]) ? p_cmax[k] : exp_mc[k] + nm;
            exp_fc[k] = (exp_fc[k] + nf > p_cmax[k]) ? p_cmax[k] : exp_fc[k] + nf;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("i%0d_match", k), 32'(m_o[k]), 32'(exp_m[k]));
            check($sformatf("i%0d_fail", k), 32'(f_o[k]), 32'(exp_f[k]));
            check($sformatf("i%0d_busy", k), 32'(b_o[k]), 32'(exp_b[k]));
            check($sformatf("i%0d_len", k), 32'(l_o[k]), 32'(exp_l[k]));
            check($sformatf("i%0d_mcnt", k), 32'(mc_o[k]), 32'(exp_mc[k]));
            check($sformatf("i%0d_fcnt", k), 32'(fc_o[k]), 32'(exp_fc[k]));
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        start_i = s; end_a_i = a; end_b_i = b;
        model_eval(s, a, b);
        @(posedge clk);
        #1;
        compare_all();
        cyc++;
    endtask

    task automatic clear_step(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        clear_i = 1'b1; start_i = s; end_a_i = a; end_b_i = b;
        model_reset();
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        compare_all();
        cyc++;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Joint end three cycles after a start on ch0.
        step(4'b0001, 4'd0, 4'd0);
        step(4'd0, 4'd0, 4'd0);
        step(4'd0, 4'd0, 4'd0);
        step(4'd0, 4'b0001, 4'b0001);
        check("t1_match", 32'(m_o[0][0]), 32'd1);
        check("t1_len", 32'(l_o[0][2:0]), 32'd3);
        check("t1_mcnt", 32'(mc_o[0]), 32'd1);

        // Split endpoints never match; the attempt expires at age 7.
        clear_step(4'd0, 4'd0, 4'd0);
        step(4'b0010, 4'd0, 4'd0);
        step(4'd0, 4'd0, 4'd0);
        step(4'd0, 4'b0010, 4'd0);
        step(4'd0, 4'd0, 4'b0010);
        for (int i = 0; i < 3; i++) step(4'd0, 4'd0, 4'd0);
        check("t2_nofail_early", 32'(f_o[0]), 32'd0);
        step(4'd0, 4'd0, 4'd0);
        check("t2_fail", 32'(f_o[0][1]), 32'd1);
        check("t2_fcnt", 32'(fc_o[0]), 32'd1);
        check("t2_mcnt", 32'(mc_o[0]), 32'd0);

        // Same-cycle start and joint end at age 0.
        clear_step(4'd0, 4'd0, 4'd0);
        step(4'b0100, 4'b0100, 4'b0100);
        check("t3_match", 32'(m_o[0][2]), 32'd1);
        check("t3_len", 32'(l_o[0][8:6]), 32'd0);
        check("t3_busy", 32'(b_o[0][2]), 32'd0);

        // Overlapping attempts: FIRST keeps two, ALL drops everything.
        clear_step(4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) step(4'b0001, 4'd0, 4'd0);
        step(4'd0, 4'd0, 4'd0);
        step(4'd0, 4'b0001, 4'b0001);
        check("t4_first_len", 32'(l_o[0][2:0]), 32'd4);
        check("t4_first_busy", 32'(b_o[0][0]), 32'd1);
        check("t4_all_len", 32'(l_o[1][2:0]), 32'd4);
        check("t4_all_busy", 32'(b_o[1][0]), 32'd0);

        // MIN_LEN = 2 rejects a joint end at age 1, accepts one at age 3.
        clear_step(4'd0, 4'd0, 4'd0);
        step(4'b0001, 4'd0, 4'd0);
        step(4'd0, 4'b0001, 4'b0001);
        check("t5_early", 32'(m_o[2][0]), 32'd0);
        step(4'd0, 4'd0, 4'd0);
        step(4'd0, 4'b0001, 4'b0001);
        check("t5_match", 32'(m_o[2][0]), 32'd1);
        check("t5_len", 32'(l_o[2][2:0]), 32'd3);

        // Counter saturation, then a reset that discards a live attempt.
        clear_step(4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001, 4'b0001);
        check("t6_sat", 32'(sat_mc), 32'd3);
        check("t6_wide", 32'(mc_o[0]), 32'd5);
        step(4'b1000, 4'd0, 4'd0);
        step(4'd0, 4'd0, 4'd0);
        pulse_reset();
        check("t6_rst_busy", 32'(b_o[0]), 32'd0);
        for (int i = 0; i < 10; i++) step(4'd0, 4'd0, 4'd0);
        check("t6_no_fail", 32'(fc_o[0]), 32'd0);

        // Randomised traffic with occasional clear and reset.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] s, a, b;
            s = 4'($urandom);
            a = 4'($urandom);
            b = 4'($urandom);
            if ($urandom_range(0, 3) != 0) s = s & 4'($urandom);
            if ($urandom_range(0, 59) == 0) clear_step(s, a, b);
            else if ($urandom_range(0, 79) == 0) pulse_reset();
            else step(s, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
